// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   - Stage index constants for the 5-stage pipeline (IF, ID, EX, MEM, WB).
//   - Width of the per-stage stall/bubble vectors.
//   - Controller FSM state encoding.
//   - Helpers that turn a stall source level into stall/bubble masks.
package pipeline_ctrl_pkg;

  localparam int STALL_W = 5;

  localparam logic [2:0] STAGE_IF  = 3'd0;
  localparam logic [2:0] STAGE_ID  = 3'd1;
  localparam logic [2:0] STAGE_EX  = 3'd2;
  localparam logic [2:0] STAGE_MEM = 3'd3;
  localparam logic [2:0] STAGE_WB  = 3'd4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_e;

  // Stall source at level k holds stages 0..k: (2 << k) - 1.
  function automatic logic [STALL_W-1:0] stall_mask(input logic [2:0] lvl);
    return (STALL_W'(2) << lvl) - STALL_W'(1);
  endfunction

  // The stage directly below the stall source receives a NOP.
  function automatic logic [STALL_W-1:0] bubble_mask(input logic [2:0] lvl);
    return STALL_W'(2) << lvl;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_counter.sv
// Saturating performance counter with synchronous clear.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : load zero (wins over en)
//   en       : count this cycle
//   cnt      : current count, sticks at all-ones
module pipeline_ctrl_stall_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage integer pipeline.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   load_related_1/2    : ID operand depends on the load currently in EX
//   stall_req_if/ex/mem : stall requests from IF, EX (mult/div), MEM (bus)
//   exc_req, exc_target : exception/eret pulse from MEM and its redirect PC
//   cnt_clear           : clear the stall-cycle counter
//   stall, bubble       : per-stage hold / NOP-insert vectors (combinational)
//   flush, flush_pc     : registered one-cycle flush and redirect target
//   stall_cycles        : saturating count of cycles with stall[1]=1
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_related_1,
  input  logic                  load_related_2,
  input  logic                  stall_req_if,
  input  logic                  stall_req_ex,
  input  logic                  stall_req_mem,
  input  logic                  exc_req,
  input  logic [ADDR_WIDTH-1:0] exc_target,
  input  logic                  cnt_clear,
  output logic [STALL_W-1:0]    stall,
  output logic [STALL_W-1:0]    bubble,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] flush_pc,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic                  flush_q, flush_d;
  logic [ADDR_WIDTH-1:0] flush_pc_q, flush_pc_d;

  logic                  lvl_vld;
  logic [2:0]            lvl;

  // Highest requesting stage wins; everything upstream of it must hold.
  always_comb begin
    lvl_vld = 1'b1;
    lvl     = STAGE_IF;
    if (stall_req_mem) begin
      lvl = STAGE_MEM;
    end else if (stall_req_ex) begin
      lvl = STAGE_EX;
    end else if (load_related_1 || load_related_2) begin
      lvl = STAGE_ID;
    end else if (stall_req_if) begin
      lvl = STAGE_IF;
    end else begin
      lvl_vld = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      tgt_q      <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // Next-state logic. The target is captured on the first exception only;
  // later pulses in PEND are dropped, and any pulse in FLUSH comes from an
  // instruction that is being killed.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      RUN: begin
        if (exc_req) begin
          tgt_d   = exc_target;
          state_d = stall_req_mem ? PEND : FLUSH;
        end
      end
      PEND: begin
        if (!stall_req_mem) begin
          state_d = FLUSH;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
    // flush/flush_pc are registered copies of "entering FLUSH"; flush_pc
    // keeps its last target otherwise.
    flush_d    = (state_d == FLUSH);
    flush_pc_d = flush_d ? tgt_d : flush_pc_q;
  end

  // Output logic. Stall/bubble are forced to zero during reset even though
  // they are combinational.
  always_comb begin
    stall  = '0;
    bubble = '0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (lvl_vld) begin
            stall  = stall_mask(lvl);
            bubble = bubble_mask(lvl);
          end
        end
        PEND: begin
          stall = '1;
        end
        default: begin
          stall  = '0;
          bubble = '0;
        end
      endcase
    end
  end

  assign flush    = flush_q;
  assign flush_pc = flush_pc_q;

  pipeline_ctrl_stall_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall_counter (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clear),
    .en (stall[STAGE_ID]),
    .cnt(stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_related_1 = 1'b0;
  logic        load_related_2 = 1'b0;
  logic        stall_req_if = 1'b0;
  logic        stall_req_ex = 1'b0;
  logic        stall_req_mem = 1'b0;
  logic        exc_req = 1'b0;
  logic [31:0] exc_target = 32'h0;
  logic        cnt_clear = 1'b0;

  logic [4:0]  stall, bubble, stall4, bubble4;
  logic        flush, flush4;
  logic [31:0] flush_pc, flush_pc4;
  logic [31:0] stall_cycles;
  logic [3:0]  stall_cycles4;

  always #5 clk = ~clk;

  pipeline_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst),
    .load_related_1(load_related_1), .load_related_2(load_related_2),
    .stall_req_if(stall_req_if), .stall_req_ex(stall_req_ex),
    .stall_req_mem(stall_req_mem), .exc_req(exc_req),
    .exc_target(exc_target), .cnt_clear(cnt_clear),
    .stall(stall), .bubble(bubble), .flush(flush), .flush_pc(flush_pc),
    .stall_cycles(stall_cycles)
  );

  pipeline_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .load_related_1(load_related_1), .load_related_2(load_related_2),
    .stall_req_if(stall_req_if), .stall_req_ex(stall_req_ex),
    .stall_req_mem(stall_req_mem), .exc_req(exc_req),
    .exc_target(exc_target), .cnt_clear(cnt_clear),
    .stall(stall4), .bubble(bubble4), .flush(flush4), .flush_pc(flush_pc4),
    .stall_cycles(stall_cycles4)
  );

  typedef struct {
    logic        rst, l1, l2, sif, sex, smem, exc, clr;
    logic [31:0] tgt;
    logic [4:0]  e_stall, e_bubble;
  } vec_t;

  typedef struct {
    logic        flush;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference model of the registered side
  int          m_state = 0;  // 0 run, 1 pending, 2 flushing
  logic [31:0] m_tgt = 0, m_pc = 0, m_cnt = 0;
  logic        m_flush = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic r, l1, l2, sif, sex, smem, exc, clr,
                              input logic [31:0] tgt, input logic [4:0] es, eb);
    vec_t v;
    v.rst = r; v.l1 = l1; v.l2 = l2; v.sif = sif; v.sex = sex; v.smem = smem;
    v.exc = exc; v.clr = clr; v.tgt = tgt; v.e_stall = es; v.e_bubble = eb;
    return v;
  endfunction

  task automatic tick(input vec_t v, input string lbl);
    exp_t e;
    @(negedge clk);
    rst = v.rst; load_related_1 = v.l1; load_related_2 = v.l2;
    stall_req_if = v.sif; stall_req_ex = v.sex; stall_req_mem = v.smem;
    exc_req = v.exc; exc_target = v.tgt; cnt_clear = v.clr;
    #1;
    chk({lbl, " stall"},   32'(stall),   32'(v.e_stall));
    chk({lbl, " bubble"},  32'(bubble),  32'(v.e_bubble));
    chk({lbl, " stall4"},  32'(stall4),  32'(v.e_stall));
    chk({lbl, " bubble4"}, 32'(bubble4), 32'(v.e_bubble));
    if (v.rst) begin
      m_state = 0; m_tgt = 0; m_pc = 0; m_cnt = 0; m_flush = 0;
    end else begin
      if (v.clr) m_cnt = 0;
      else if (v.e_stall[1]) m_cnt = m_cnt + 1;
      m_flush = 0;
      case (m_state)
        0: if (v.exc) begin
             m_tgt = v.tgt;
             if (v.smem) m_state = 1;
             else begin m_state = 2; m_flush = 1; m_pc = v.tgt; end
           end
        1: if (!v.smem) begin m_state = 2; m_flush = 1; m_pc = m_tgt; end
        default: m_state = 0;
      endcase
    end
    e.flush = m_flush; e.pc = m_pc; e.cnt = m_cnt;
    e.cnt4 = (m_cnt > 32'd15) ? 4'hF : m_cnt[3:0];
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({lbl, " flush"},     32'(flush),         32'(e.flush));
    chk({lbl, " flush_pc"},  flush_pc,           e.pc);
    chk({lbl, " flush4"},    32'(flush4),        32'(e.flush));
    chk({lbl, " flush_pc4"}, flush_pc4,          e.pc);
    chk({lbl, " cnt"},       stall_cycles,       e.cnt);
    chk({lbl, " cnt4"},      32'(stall_cycles4), 32'(e.cnt4));
  endtask

  vec_t tbl[12];

  initial begin
    //             rst l1 l2 if ex mem exc clr tgt   stall     bubble
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000);
    tbl[1]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 5'b00001, 5'b00010);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00011, 5'b00100);
    tbl[3]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00011, 5'b00100);
    tbl[4]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 5'b00011, 5'b00100);
    tbl[5]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b00111, 5'b01000);
    tbl[6]  = mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 5'b00111, 5'b01000);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b01111, 5'b10000);
    tbl[8]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 5'b01111, 5'b10000);
    tbl[9]  = mk(0, 1, 1, 1, 1, 1, 0, 0, 0, 5'b01111, 5'b10000);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 5'b00011, 5'b00100);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00011, 5'b00100);

    // Reset with active requests: outputs must stay zero
    tick(mk(1, 1, 0, 0, 0, 1, 1, 0, 32'hDEAD0000, 5'b0, 5'b0), "reset0");
    tick(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 5'b0), "reset1");

    for (int i = 0; i < 12; i++) tick(tbl[i], $sformatf("vec%0d", i));

    // Undeferred exception; requests and a new exc in the FLUSH cycle are ignored
    tick(mk(0, 0, 0, 0, 0, 0, 1, 0, 32'hBFC00380, 5'b0, 5'b0), "exc_now");
    tick(mk(0, 1, 0, 0, 0, 1, 1, 0, 32'h00001234, 5'b0, 5'b0), "exc_flush");
    tick(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 5'b0), "exc_run");

    // Deferred exception behind an outstanding MEM transaction
    tick(mk(0, 0, 0, 0, 0, 1, 1, 0, 32'h80000180, 5'b01111, 5'b10000), "def_req");
    tick(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11111, 5'b0), "def_pend0");
    tick(mk(0, 0, 1, 0, 0, 1, 1, 0, 32'h00001234, 5'b11111, 5'b0), "def_pend1");
    tick(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11111, 5'b0), "def_pend2");
    tick(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b0), "def_release");
    tick(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 5'b0, 5'b0), "def_flush");
    tick(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00011, 5'b00100), "def_run");

    // Reset while pending drops the exception
    tick(mk(0, 0, 0, 0, 0, 1, 1, 0, 32'h80000200, 5'b01111, 5'b10000), "rp_req");
    tick(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11111, 5'b0), "rp_pend");
    tick(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 5'b0, 5'b0), "rp_reset");
    tick(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 5'b0), "rp_after0");
    tick(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 5'b0), "rp_after1");

    // Counter: clear with stall, run the 4-bit build to 4'hE, then saturate
    tick(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 5'b00011, 5'b00100), "sat_clr");
    for (int i = 0; i < 14; i++)
      tick(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00011, 5'b00100), $sformatf("sat_up%0d", i));
    for (int i = 0; i < 3; i++)
      tick(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00011, 5'b00100), $sformatf("sat_top%0d", i));
    tick(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 5'b0), "sat_idle");
    tick(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 5'b00011, 5'b00100), "sat_clr2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
